// File: rtl/debounce_fsm_pkg.sv
// Shared definitions for the debounce stage: state encodings and default
// timing parameters, so the top level and benches draw from one source.
package debounce_fsm_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_RISE_WAIT = 2'd1,
      S_HIGH      = 2'd2,
      S_FALL_WAIT = 2'd3
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES   = 16;
   localparam int DEF_LONG_PRESS_CYCLES = 1000;
   localparam int DEF_EVT_W             = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Debounces a synchronised input level and extracts rise/fall/long-press
// pulses plus a wrapping press counter. All outputs are registered.
module debounce_fsm
   import debounce_fsm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int EVT_W             = DEF_EVT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_sync,
   output logic             level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             long_pulse,
   output logic             long_active,
   output logic [EVT_W-1:0] press_count,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES) + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_level;
   logic               r_rise;
   logic               r_fall;
   logic               r_long;
   logic               r_long_active;
   logic [EVT_W-1:0]   r_press_count;
   logic               w_level_nxt;
   logic               w_rise_nxt;
   logic               w_fall_nxt;
   logic               w_long_nxt;
   logic               w_long_active_nxt;
   logic [EVT_W-1:0]   w_press_nxt;
   logic               w_db_done;
   logic               w_long_hit;

   assign w_db_done  = (r_cnt == DB_LAST);
   assign w_long_hit = (r_cnt == LP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_LOW;
         r_cnt         <= '0;
         r_level       <= 1'b0;
         r_rise        <= 1'b0;
         r_fall        <= 1'b0;
         r_long        <= 1'b0;
         r_long_active <= 1'b0;
         r_press_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_level       <= w_level_nxt;
         r_rise        <= w_rise_nxt;
         r_fall        <= w_fall_nxt;
         r_long        <= w_long_nxt;
         r_long_active <= w_long_active_nxt;
         r_press_count <= w_press_nxt;
      end
   end

   // One counter serves debounce timing in the wait states and long-press
   // timing in S_HIGH; it saturates at the long threshold.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_LOW: begin
            if (din_sync) begin
               w_state_nxt = S_RISE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_RISE_WAIT: begin
            if (!din_sync) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
            end else if (w_db_done) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!din_sync) begin
               w_state_nxt = S_FALL_WAIT;
               w_cnt_nxt   = '0;
            end else if (r_cnt < LP_LAST) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_FALL_WAIT: begin
            if (din_sync) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
            end else if (w_db_done) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // long_active survives a release bounce so one press yields one long_pulse.
   always_comb begin
      w_level_nxt       = r_level;
      w_rise_nxt        = 1'b0;
      w_fall_nxt        = 1'b0;
      w_long_nxt        = 1'b0;
      w_long_active_nxt = r_long_active;
      w_press_nxt       = r_press_count;
      case (r_state)
         S_RISE_WAIT: begin
            if (din_sync && w_db_done) begin
               w_level_nxt = 1'b1;
               w_rise_nxt  = 1'b1;
               w_press_nxt = r_press_count + EVT_W'(1);
            end
         end
         S_HIGH: begin
            if (din_sync && !r_long_active && w_long_hit) begin
               w_long_nxt        = 1'b1;
               w_long_active_nxt = 1'b1;
            end
         end
         S_FALL_WAIT: begin
            if (!din_sync && w_db_done) begin
               w_level_nxt       = 1'b0;
               w_fall_nxt        = 1'b1;
               w_long_active_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign level       = r_level;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign long_pulse  = r_long;
   assign long_active = r_long_active;
   assign press_count = r_press_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: directed scenarios then random segments, all
// checked each cycle against a run-length reference model.
module tb_debounce_fsm;

   localparam int DB = 4;
   localparam int LP = 10;
   localparam int EW = 8;

   logic          clk;
   logic          reset;
   logic          din_sync;
   logic          level;
   logic          rise_pulse;
   logic          fall_pulse;
   logic          long_pulse;
   logic          long_active;
   logic [EW-1:0] press_count;
   logic [1:0]    dbg_state;

   int n_tests;
   int n_fail;

   // reference model state
   logic          m_level;
   logic          m_rise;
   logic          m_fall;
   logic          m_long;
   logic          m_long_active;
   logic [EW-1:0] m_press;
   int            m_opp_run;
   int            m_hold;
   logic          m_dipped;

   debounce_fsm #(
      .DEBOUNCE_CYCLES  (DB),
      .LONG_PRESS_CYCLES(LP),
      .EVT_W            (EW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din_sync   (din_sync),
      .level      (level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .long_pulse (long_pulse),
      .long_active(long_active),
      .press_count(press_count),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_level       = 1'b0;
      m_rise        = 1'b0;
      m_fall        = 1'b0;
      m_long        = 1'b0;
      m_long_active = 1'b0;
      m_press       = '0;
      m_opp_run     = 0;
      m_hold        = 0;
      m_dipped      = 1'b0;
   endtask

   // A level commits after DB+1 consecutive samples opposite to it; a long
   // press is LP consecutive high samples after the commit or a return from a dip.
   task automatic model_step(input logic d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_long = 1'b0;
      if (d != m_level) m_opp_run++;
      else              m_opp_run = 0;
      if (m_opp_run == DB + 1) begin
         m_level   = d;
         m_opp_run = 0;
         if (d) begin
            m_rise   = 1'b1;
            m_press  = m_press + 1'b1;
            m_hold   = 0;
            m_dipped = 1'b0;
         end else begin
            m_fall        = 1'b1;
            m_long_active = 1'b0;
         end
      end else if (m_level) begin
         if (!d) begin
            m_dipped = 1'b1;
         end else if (m_dipped) begin
            m_dipped = 1'b0;
            m_hold   = 0;
         end else begin
            m_hold++;
            if (m_hold == LP && !m_long_active) begin
               m_long        = 1'b1;
               m_long_active = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"},       level,       m_level);
      chk({tag, ".rise"},        rise_pulse,  m_rise);
      chk({tag, ".fall"},        fall_pulse,  m_fall);
      chk({tag, ".long"},        long_pulse,  m_long);
      chk({tag, ".long_active"}, long_active, m_long_active);
      chk({tag, ".press_count"}, press_count, m_press);
   endtask

   task automatic tick(input logic d);
      din_sync = d;
      @(posedge clk);
      if (reset) model_step(d);
      #1;
      check_all("cyc");
   endtask

   task automatic ticks(input logic d, input int n);
      for (int i = 0; i < n; i++) tick(d);
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      din_sync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      check_all("rst");
      chk("rst.state", dbg_state, 2'd0);
      #2 reset = 1'b1;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      reset    = 1'b0;
      din_sync = 1'b0;
      model_clear();
      do_reset();

      // clean press held 20 cycles
      ticks(1'b0, 3);
      ticks(1'b1, 4);
      chk("clean.pre_level", level, 1'b0);
      tick(1'b1);
      chk("clean.rise", rise_pulse, 1'b1);
      chk("clean.press", press_count, 8'd1);
      ticks(1'b1, 9);
      chk("clean.no_long_early", long_pulse, 1'b0);
      tick(1'b1);
      chk("clean.long", long_pulse, 1'b1);
      chk("clean.long_active", long_active, 1'b1);
      ticks(1'b1, 5);
      ticks(1'b0, 5);
      chk("clean.fall", fall_pulse, 1'b1);
      chk("clean.long_cleared", long_active, 1'b0);

      // press bounce: no commit
      ticks(1'b0, 3);
      ticks(1'b1, 3);
      tick(1'b0);
      ticks(1'b1, 2);
      ticks(1'b0, 6);
      chk("bounce.level", level, 1'b0);
      chk("bounce.press", press_count, 8'd1);

      // release bounce before any long press
      ticks(1'b1, 5);
      ticks(1'b1, 2);
      ticks(1'b0, 2);
      tick(1'b1);
      ticks(1'b0, 4);
      chk("relb.no_fall_yet", level, 1'b1);
      tick(1'b0);
      chk("relb.fall", fall_pulse, 1'b1);
      chk("relb.long_active", long_active, 1'b0);

      // long press with a short dip afterwards
      ticks(1'b0, 2);
      ticks(1'b1, 5);
      ticks(1'b1, 12);
      chk("lpdip.active", long_active, 1'b1);
      ticks(1'b0, 2);
      ticks(1'b1, 15);
      chk("lpdip.still_active", long_active, 1'b1);
      ticks(1'b0, 5);
      chk("lpdip.cleared", long_active, 1'b0);

      // press counter wrap
      do_reset();
      for (int p = 0; p < 256; p++) begin
         ticks(1'b1, 5);
         ticks(1'b0, 5);
      end
      chk("wrap.256", press_count, 8'd0);
      ticks(1'b1, 5);
      ticks(1'b0, 5);
      chk("wrap.257", press_count, 8'd1);

      // async reset mid rise debounce
      ticks(1'b0, 2);
      ticks(1'b1, 3);
      #2 reset = 1'b0;
      #1;
      model_clear();
      check_all("areset");
      ticks(1'b1, 2);
      #2 reset = 1'b1;
      ticks(1'b1, 4);
      chk("areset.no_rise_early", rise_pulse, 1'b0);
      tick(1'b1);
      chk("areset.rise", rise_pulse, 1'b1);
      chk("areset.press", press_count, 8'd1);

      // random segments of varying length
      for (int s = 0; s < 80; s++) begin
         ticks(s[0], $urandom_range(1, 14));
      end
      ticks(1'b0, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
